// File: rtl/pwm_demod.sv
// ============================================================================
// Module   : pwm_demod
// Purpose  : Recovers the duty code of a PWM input by counting high cycles per window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_demod #(
    parameter int CYCLES_PER_WINDOW = 1024,
    parameter int CODE_WIDTH        = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pwm_in,
    output logic [CODE_WIDTH-1:0] code_out,
    output logic                  code_valid,
    input  logic                  code_ready,
    output logic                  overrun
);

    localparam logic [0:0] ST_ALIGN   = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    localparam logic [CODE_WIDTH-1:0] LAST_CNT = CODE_WIDTH'(CYCLES_PER_WINDOW - 1);
    localparam logic [CODE_WIDTH-1:0] CNT_ONE  = CODE_WIDTH'(1);
    localparam logic [CODE_WIDTH-1:0] CODE_MAX = '1;

    logic                  sync1_q, pwm_s_q, pwm_d_q;
    logic [0:0]            state_q, state_d;
    logic [CODE_WIDTH-1:0] align_cnt_q, align_cnt_d;
    logic [CODE_WIDTH-1:0] win_cnt_q, win_cnt_d;
    logic [CODE_WIDTH:0]   high_cnt_q, high_cnt_d;
    logic [CODE_WIDTH-1:0] code_q, code_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;

    logic                  rise;
    logic                  window_done;
    logic [CODE_WIDTH:0]   high_sum;

    assign rise        = pwm_s_q & ~pwm_d_q;
    assign window_done = (state_q == ST_MEASURE) && (win_cnt_q == LAST_CNT);
    // The final cycle of the window is counted here rather than in the counter.
    assign high_sum    = high_cnt_q + {{CODE_WIDTH{1'b0}}, pwm_s_q};

    always_comb begin
        state_d     = state_q;
        align_cnt_d = align_cnt_q;
        win_cnt_d   = win_cnt_q;
        high_cnt_d  = high_cnt_q;
        code_d      = code_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;

        if (state_q == ST_ALIGN) begin
            align_cnt_d = align_cnt_q + CNT_ONE;
            if (rise || (align_cnt_q == LAST_CNT)) begin
                state_d     = ST_MEASURE;
                align_cnt_d = '0;
                win_cnt_d   = '0;
                high_cnt_d  = '0;
            end
        end else begin
            win_cnt_d  = win_cnt_q + CNT_ONE;
            high_cnt_d = high_sum;
            if (window_done) begin
                win_cnt_d  = '0;
                high_cnt_d = '0;
                code_d     = high_sum[CODE_WIDTH] ? CODE_MAX : high_sum[CODE_WIDTH-1:0];
            end
        end

        // A completing window wins over a same-cycle accept, without flagging overrun.
        if (window_done) begin
            valid_d = 1'b1;
            if (valid_q && !code_ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && code_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            pwm_s_q     <= 1'b0;
            pwm_d_q     <= 1'b0;
            state_q     <= ST_ALIGN;
            align_cnt_q <= '0;
            win_cnt_q   <= '0;
            high_cnt_q  <= '0;
            code_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= pwm_in;
            pwm_s_q     <= sync1_q;
            pwm_d_q     <= pwm_s_q;
            state_q     <= state_d;
            align_cnt_q <= align_cnt_d;
            win_cnt_q   <= win_cnt_d;
            high_cnt_q  <= high_cnt_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign code_out   = code_q;
    assign code_valid = valid_q;
    assign overrun    = overrun_q;

endmodule

`default_nettype wire
